// File: rtl/spu_loader_pkg.sv
// rtl/spu_loader_pkg.sv - shared types and constants for the spu program loader
package spu_loader_pkg;

    // Loader FSM states
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_CSUM,
        ST_START,
        ST_ARM,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } state_t;

    // A zero length header stands for the largest program (2^ADDR_W words)
    localparam logic [7:0] HDR_MAX_CODE = 8'h00;

    // Each im word is packed from this many stream bytes, high byte first
    localparam int BYTES_PER_WORD = 2;

endpackage

// File: rtl/spu_loader_pack.sv
// rtl/spu_loader_pack.sv - packs big-endian byte pairs into im words and drives the im write port
module spu_loader_pack
    import spu_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_hi_en,
    input  logic              i_lo_en,
    input  logic [7:0]        i_data,
    output logic [ADDR_W-1:0] o_idx,
    output logic [ADDR_W-1:0] o_w_addr,
    output logic [DATA_W-1:0] o_w_data,
    output logic              o_wr
);

    localparam int BYTE_W = DATA_W / BYTES_PER_WORD;

    logic [BYTE_W-1:0] r_hi;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_w_addr;
    logic [DATA_W-1:0] r_w_data;
    logic              r_wr;

    // Hold the high byte, then emit one write per low byte; address/data hold between writes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hi     <= '0;
            r_idx    <= '0;
            r_w_addr <= '0;
            r_w_data <= '0;
            r_wr     <= 1'b0;
        end else begin
            r_wr <= 1'b0;
            if (i_clr) begin
                r_idx <= '0;
            end
            if (i_hi_en) begin
                r_hi <= BYTE_W'(i_data);
            end
            if (i_lo_en) begin
                r_wr     <= 1'b1;
                r_w_data <= {r_hi, BYTE_W'(i_data)};
                r_w_addr <= r_idx;
                r_idx    <= r_idx + 1'b1;
            end
        end
    end

    assign o_idx    = r_idx;
    assign o_w_addr = r_w_addr;
    assign o_w_data = r_w_data;
    assign o_wr     = r_wr;

endmodule

// File: rtl/spu_loader.sv
// rtl/spu_loader.sv - loads im from a byte stream, starts spu and times the run (optional LOADER_CSUM_EN)
module spu_loader
    import spu_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic [ADDR_W-1:0] im_w_addr,
    output logic [DATA_W-1:0] im_w_data,
    output logic              im_wr,
    output logic              spu_start,
    input  logic              spu_stop,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  run_cycles
);

    state_t            r_state;
    logic              r_in_ready;
    logic              r_spu_start;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_run_cycles;
    logic [ADDR_W-1:0] r_last_idx;
`ifdef LOADER_CSUM_EN
    logic              r_err;
    logic [7:0]        r_csum;
`endif

    logic              w_accept;
    logic              w_hdr;
    logic              w_hi_en;
    logic              w_lo_en;
    logic [ADDR_W-1:0] w_idx;
    logic [CNT_W-1:0]  w_run_inc;

    assign w_accept  = in_valid && r_in_ready;
    assign w_hdr     = w_accept && (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR);
    assign w_hi_en   = w_accept && (r_state == ST_HI);
    assign w_lo_en   = w_accept && (r_state == ST_LO);
    assign w_run_inc = (&r_run_cycles) ? r_run_cycles : r_run_cycles + 1'b1;

    spu_loader_pack #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pack (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_clr    (w_hdr),
        .i_hi_en  (w_hi_en),
        .i_lo_en  (w_lo_en),
        .i_data   (in_data),
        .o_idx    (w_idx),
        .o_w_addr (im_w_addr),
        .o_w_data (im_w_data),
        .o_wr     (im_wr)
    );

    // Loader FSM with registered handshake, status and run-cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b1;
            r_spu_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_run_cycles <= '0;
            r_last_idx   <= '0;
`ifdef LOADER_CSUM_EN
            r_err        <= 1'b0;
            r_csum       <= '0;
`endif
        end else begin
            r_spu_start <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (w_accept) begin
                        r_last_idx   <= (in_data == HDR_MAX_CODE) ? '1 : ADDR_W'(in_data - 8'd1);
                        r_done       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_run_cycles <= '0;
                        r_state      <= ST_HI;
`ifdef LOADER_CSUM_EN
                        r_err        <= 1'b0;
                        r_csum       <= in_data;
`endif
                    end
                end
                ST_HI: begin
                    if (w_accept) begin
`ifdef LOADER_CSUM_EN
                        r_csum  <= r_csum ^ in_data;
`endif
                        r_state <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (w_accept) begin
`ifdef LOADER_CSUM_EN
                        r_csum <= r_csum ^ in_data;
`endif
                        if (w_idx == r_last_idx) begin
`ifdef LOADER_CSUM_EN
                            r_state     <= ST_CSUM;
`else
                            r_state     <= ST_START;
                            r_spu_start <= 1'b1;
                            r_in_ready  <= 1'b0;
`endif
                        end else begin
                            r_state <= ST_HI;
                        end
                    end
                end
`ifdef LOADER_CSUM_EN
                ST_CSUM: begin
                    if (w_accept) begin
                        if (r_csum == in_data) begin
                            r_state     <= ST_START;
                            r_spu_start <= 1'b1;
                            r_in_ready  <= 1'b0;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
`endif
                ST_START: begin
                    r_run_cycles <= w_run_inc;
                    r_state      <= ST_ARM;
                end
                ST_ARM: begin
                    r_run_cycles <= w_run_inc;
                    if (!spu_stop) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_run_cycles <= w_run_inc;
                    if (spu_stop) begin
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign spu_start  = r_spu_start;
    assign busy       = r_busy;
    assign done       = r_done;
    assign run_cycles = r_run_cycles;
`ifdef LOADER_CSUM_EN
    assign err        = r_err;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_spu_loader.sv
// tb/tb_spu_loader.sv - directed self-checking bench for spu_loader
module tb_spu_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [7:0]  im_w_addr;
    logic [15:0] im_w_data;
    logic        im_wr;
    logic        spu_start;
    logic        spu_stop;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] run_cycles;

    int          n_pass;
    int          n_chk;
    int          n_tmo;
    int          n_starts;
    int          wr_at_start;
    int          rdy_drop;
    logic [23:0] wq[$];

    spu_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .im_w_addr  (im_w_addr),
        .im_w_data  (im_w_data),
        .im_wr      (im_wr),
        .spu_start  (spu_start),
        .spu_stop   (spu_stop),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .run_cycles (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // im write log and start-pulse counter
    always @(negedge clk) begin
        if (im_wr) wq.push_back({im_w_addr, im_w_data});
        if (spu_start) begin
            n_starts    = n_starts + 1;
            wr_at_start = wq.size();
        end
    end

    // spu model: drops stop on start, raises it 10 cycles later
    always begin
        @(negedge clk);
        if (spu_start) begin
            spu_stop = 1'b0;
            repeat (10) @(negedge clk);
            spu_stop = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) n_tmo = n_tmo + 1;
        @(negedge clk);
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (!in_ready) rdy_drop = rdy_drop + 1;
        end
    endtask

    task automatic wait_end();
        int n;
        n        = 0;
        in_valid = 1'b0;
        while (!(done || err) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) n_tmo = n_tmo + 1;
    endtask

    initial begin
        int s0;
        int s1;
        int n;
        n_pass = 0; n_chk = 0; n_tmo = 0; n_starts = 0; wr_at_start = 0; rdy_drop = 0;
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; spu_stop = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_flags", {busy, done, err, im_wr, spu_start}, 0);
        chk("rst_bus", {run_cycles, im_w_addr, im_w_data}, 0);
        rst = 1'b1;
        @(negedge clk);

        // two-word load, continuous valid
        wq.delete();
        s0 = n_starts;
        send(8'h02);
        chk("a_busy", busy, 1);
        send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
        wait_end();
        chk("a_nwr", wq.size(), 2);
        chk("a_w0", wq[0], 24'h00_1234);
        chk("a_w1", wq[1], 24'h01_ABCD);
        chk("a_start_after", wr_at_start, 2);
        chk("a_nstart", n_starts - s0, 1);
        chk("a_run", run_cycles, 11);
        chk("a_done_busy", {done, busy, in_ready}, 3'b101);

        // max-length load via zero header
        wq.delete();
        s0 = n_starts;
        send(8'h00);
        chk("b_hdr_clr", {done, run_cycles}, 0);
        for (int i = 0; i < 512; i++) send(i[7:0]);
        wait_end();
        chk("b_nwr", wq.size(), 256);
        for (int k = 0; k < 256; k++) begin
            logic [7:0] a;
            logic [7:0] h;
            logic [7:0] l;
            a = k[7:0];
            h = 8'(2 * k);
            l = 8'(2 * k + 1);
            chk($sformatf("b_w%0d", k), wq[k], {a, h, l});
        end
        chk("b_start_after", wr_at_start, 256);
        chk("b_nstart", n_starts - s0, 1);

        // one-word load with 3-cycle gaps
        wq.delete();
        send(8'h01); gap(3);
        send(8'h5A); gap(3);
        send(8'h5A);
        wait_end();
        chk("c_ready_held", rdy_drop, 0);
        chk("c_nwr", wq.size(), 1);
        chk("c_w0", wq[0], 24'h00_5A5A);

        // reset mid-run, then a fresh load
        wq.delete();
        s0 = n_starts;
        send(8'h01); send(8'hAA); send(8'hBB);
        in_valid = 1'b0;
        n = 0;
        while (n_starts == s0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) n_tmo = n_tmo + 1;
        repeat (4) @(negedge clk);
        chk("d_in_run", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("d_rst_flags", {busy, done, err, im_wr, spu_start}, 0);
        chk("d_rst_bus", {run_cycles, im_w_addr, im_w_data}, 0);
        chk("d_rst_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        s1 = n_starts;
        repeat (14) @(negedge clk);
        chk("d_no_restart", n_starts - s1, 0);
        chk("d_ready_after", in_ready, 1);
        wq.delete();
        send(8'h01); send(8'h11); send(8'h22);
        wait_end();
        chk("d_nwr", wq.size(), 1);
        chk("d_w0", wq[0], 24'h00_1122);
        chk("d_run", run_cycles, 11);
        chk("d_done", done, 1);

`ifdef LOADER_CSUM_EN
        // checksum good then bad
        wq.delete();
        s0 = n_starts;
        send(8'h01); send(8'h12); send(8'h34); send(8'h27);
        wait_end();
        chk("e_good_start", n_starts - s0, 1);
        chk("e_good_flags", {done, err}, 2'b10);
        s0 = n_starts;
        send(8'h01); send(8'h12); send(8'h34); send(8'h00);
        wait_end();
        repeat (3) @(negedge clk);
        chk("e_bad_flags", {err, done, busy, in_ready}, 4'b1001);
        chk("e_bad_nostart", n_starts - s0, 0);
        send(8'h01);
        chk("e_err_clr", err, 0);
        send(8'h00); send(8'h00); send(8'h01);
        wait_end();
        chk("e_recover", {done, err}, 2'b10);
`endif

        chk("timeouts", n_tmo, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spu_loader.md
Name: spu_loader

Overview:
- Program loader upstream of spu; fills instruction memory (im) from a byte stream, then launches the processor and waits for it to halt.
- Accepts bytes over a valid/ready handshake, packs big-endian 16-bit words, writes them to im at consecutive addresses from 0.
- Pulses spu start, counts run cycles until spu stop, reports done.

Parameters:
- ADDR_W, 8, im address width; max program length 2^ADDR_W words.
- DATA_W, 16, im word width; fixed at 2 bytes per word.
- CNT_W, 16, run-cycle counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  byte-stream valid.
- in_ready  out  1  byte-stream ready; a byte transfers when in_valid && in_ready.
- in_data  in  8  stream byte.
- im_w_addr  out  ADDR_W  im write address.
- im_w_data  out  DATA_W  im write data.
- im_wr  out  1  im write enable, one cycle per word.
- spu_start  out  1  one-cycle start pulse to spu.
- spu_stop  in  1  spu stopped indicator.
- busy  out  1  high from first accepted byte until DONE or ERR.
- done  out  1  high in DONE; held until the next header byte is accepted.
- err  out  1  checksum error, sticky until the next header byte is accepted.
- run_cycles  out  CNT_W  cycles from the start pulse to stop rise, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE.
  - All outputs 0, except in_ready=1.
  - Counters, address and byte holding register cleared.
- States:
  - IDLE: in_ready=1. Accepted byte is the length header L; word count N = L, with L=0 meaning 2^ADDR_W. Clear done/err/run_cycles, go to HI.
  - HI: in_ready=1. Accepted byte goes to hi_reg; go to LO.
  - LO: in_ready=1. On accept, next cycle: im_wr=1, im_w_data={hi_reg,byte}, im_w_addr=word index.
    - Index increments after each write.
    - If the index was N-1, go to CSUM (when LOADER_CSUM_EN is defined) or START. Otherwise go to HI.
  - START: in_ready=0, spu_start=1 for exactly 1 cycle; go to ARM.
  - ARM: wait for spu_stop=0; go to RUN. run_cycles counts every cycle from START onward.
  - RUN: count until spu_stop=1, then go to DONE. Counter saturates at all-ones with no wrap.
  - DONE: done=1, busy=0, in_ready=1. An accepted byte is a new header: behave as in IDLE.
- Timing rules:
  - in_ready is a registered function of state only; no combinational path from in_valid.
  - Throughput is 1 byte/cycle; the im write lags the LO accept by exactly 1 cycle.
  - in_valid low in HI/LO: hold state; partial word retained indefinitely.
  - im_wr never asserted outside the LO write cycle; im_w_addr/im_w_data hold their last values otherwise.
  - spu_stop already low at START is legal: ARM exits on the next cycle.
- Reset mid-load or mid-run: immediate return to IDLE. im contents already written stay; spu_start never re-pulsed.

Optional Feature:
- LOADER_CSUM_EN defined:
  - After the last word, a CSUM state (in_ready=1) accepts one byte C.
  - C must equal the XOR of L and all payload bytes.
  - Match: go to START.
  - Mismatch: go to ERR (err=1, busy=0, in_ready=1, spu_start never pulsed). A new header byte leaves ERR as from IDLE.
- Undefined: no CSUM state; err tied 0; flow goes LO directly to START.

Decomposition:
- Package spu_loader_pkg holds:
  - the state enum (IDLE, HI, LO, CSUM, START, ARM, RUN, DONE, ERR);
  - the header-zero-means-max constant;
  - the byte-per-word constant.
- One natural sub-module, spu_loader_pack: byte-to-word packer holding hi_reg, the address counter and the im write strobe.
- FSM, checksum and run counter stay in spu_loader.

Test Plan:
- Header 0x02, bytes 12 34 AB CD, continuous valid:
  - im_wr at addr 0 with 0x1234, then at addr 1 with 0xABCD;
  - then one spu_start pulse.
- Header 0x00: 512 payload bytes produce 256 writes with addresses 0..255, no extra write; start after the addr 255 write.
- in_valid gaps of 3 cycles between every byte of a 1-word load:
  - data 0x5A5A written once;
  - in_ready never deasserts during HI/LO.
- After start, model holds spu_stop=0 for 10 cycles, then raises it: run_cycles=11 (START cycle plus ARM cycle plus RUN cycles to the stop rise, per model timing), done=1, busy=0.
- Assert rst low mid-RUN:
  - all outputs 0 asynchronously, in_ready=1 after release;
  - a new load then completes normally.
- LOADER_CSUM_EN, header 0x01, bytes 12 34, checksum byte 0x27 (=01^12^34): start pulses. Same load with checksum 0x00: err=1 and no spu_start.
